// File: rtl/dma_pkg.sv
// Shared defaults, descriptor type and FSM encoding for the multi-channel DMA arbiter.
package dma_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_LEN_W  = 16;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] src;
    logic [DEF_ADDR_W-1:0] dst;
    logic [DEF_LEN_W-1:0]  len;
  } dma_desc_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_COMPLETE,
    ST_SKIP
  } arb_state_t;

  // Channel index reached by stepping `offset` places past `last`, wrapping at n.
  function automatic int rr_index(input int last, input int offset, input int n);
    return (last + offset) % n;
  endfunction

endpackage

// File: rtl/dma_rr_picker.sv
// Combinational rotate-priority encoder: picks the first requester after last_grant_i, with wrap.
module dma_rr_picker
  import dma_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  last_grant_i,
  output logic [IDX_W-1:0]  grant_o,
  output logic              valid_o
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    grant_o = '0;
    valid_o = 1'b0;
    idx     = '0;
    // Scan from the farthest offset back toward last_grant+1 so the nearest requester is written last.
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = IDX_W'(rr_index(int'(last_grant_i), k, NUM_CH));
      if (req_i[idx]) begin
        grant_o = idx;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_ch_arbiter.sv
// Round-robin front end sharing one DMA engine between NUM_CH requesters.
// Optional WAIT-state watchdog with engine abort is built when DMA_ARB_TIMEOUT_EN is defined.
module dma_ch_arbiter
  import dma_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int TIMEOUT = 65535
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0]              ch_req,
  input  logic [NUM_CH-1:0][ADDR_W-1:0]  ch_src_addr,
  input  logic [NUM_CH-1:0][ADDR_W-1:0]  ch_dst_addr,
  input  logic [NUM_CH-1:0][LEN_W-1:0]   ch_len,
  output logic [NUM_CH-1:0]              ch_ack,
  output logic [NUM_CH-1:0]              ch_done,
  output logic [NUM_CH-1:0]              ch_err,
  output logic                           start,
  output logic [ADDR_W-1:0]              src_addr,
  output logic [ADDR_W-1:0]              dst_addr,
  output logic [LEN_W-1:0]               transfer_length,
  input  logic                           eng_done,
  output logic                           eng_abort,
  output logic                           busy,
  output logic [$clog2(NUM_CH)-1:0]      active_ch
);

  localparam int               IDX_W   = $clog2(NUM_CH);
  localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(NUM_CH - 1);

  if (NUM_CH < 2 || NUM_CH > 8 || TIMEOUT < 2) begin : g_bad_param
    $error("dma_ch_arbiter: NUM_CH must be 2..8 and TIMEOUT at least 2");
  end

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  last_q, last_d, ch_q, ch_d, pick_idx;
  logic              pick_valid;
  logic [NUM_CH-1:0] ack_q, ack_d, done_q, done_d;
  logic              start_q, start_d, busy_q, busy_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              eng_done_ok;

`ifdef DMA_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0] err_q, err_d;
  logic              abort_q, abort_d;
`endif

  dma_rr_picker #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_picker (
    .req_i        (ch_req),
    .last_grant_i (last_q),
    .grant_o      (pick_idx),
    .valid_o      (pick_valid)
  );

  // The start cycle is already WAIT; completion reported alongside start is not trusted.
  assign eng_done_ok = eng_done & ~start_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    ch_d    = ch_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    ack_d   = '0;
    done_d  = '0;
    start_d = 1'b0;
`ifdef DMA_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = '0;
    abort_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          ch_d            = pick_idx;
          src_d           = ch_src_addr[pick_idx];
          dst_d           = ch_dst_addr[pick_idx];
          len_d           = ch_len[pick_idx];
          ack_d[pick_idx] = 1'b1;
          state_d         = (ch_len[pick_idx] == '0) ? ST_SKIP : ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        start_d = 1'b1;
        state_d = ST_WAIT;
`ifdef DMA_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ST_WAIT: begin
        // Completion is resolved on the WAIT exit so ch_done lands one cycle after eng_done
        // and IDLE can re-arbitrate in that same cycle.
        if (eng_done_ok) begin
          done_d[ch_q] = 1'b1;
          last_d       = ch_q;
          state_d      = ST_IDLE;
        end
`ifdef DMA_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          done_d[ch_q] = 1'b1;
          err_d[ch_q]  = 1'b1;
          abort_d      = 1'b1;
          last_d       = ch_q;
          state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_COMPLETE, ST_SKIP: begin
        done_d[ch_q] = 1'b1;
        last_d       = ch_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= LAST_CH;
      ch_q    <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      last_q  <= last_d;
      ch_q    <= ch_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

`ifdef DMA_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      err_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      abort_q <= abort_d;
    end
  end

  assign ch_err    = err_q;
  assign eng_abort = abort_q;
`else
  assign ch_err    = '0;
  assign eng_abort = 1'b0;
`endif

  assign ch_ack          = ack_q;
  assign ch_done         = done_q;
  assign start           = start_q;
  assign busy            = busy_q;
  assign active_ch       = ch_q;
  assign src_addr        = src_q;
  assign dst_addr        = dst_q;
  assign transfer_length = len_q;

endmodule
